// File: rtl/mem_loader.sv
// Byte-stream program loader: writes mem while the core is held in reset.
// Optional readback verify is built only when MEM_LOADER_VERIFY_EN is defined.
module mem_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  core_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef MEM_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  accept;
  logic                  last;

`ifdef MEM_LOADER_VERIFY_EN
  logic [ADDR_WIDTH-1:0] vcount_q, vcount_d;
  logic [DATA_WIDTH-1:0] rsum_q, rsum_d;
  logic [DATA_WIDTH-1:0] rsum_next;
  assign rsum_next = rsum_q + mem_dout;
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout;
`endif

  assign accept = (state_q == S_LOAD) && s_valid;
  assign last   = (count_q == len_q - ONE);

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    count_d  = count_q;
    csum_d   = csum_q;
`ifdef MEM_LOADER_VERIFY_EN
    vcount_d = vcount_q;
    rsum_d   = rsum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          count_d = '0;
          csum_d  = '0;
          state_d = (length == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          count_d = count_q + ONE;
          csum_d  = csum_q + s_data;
          if (last) begin
`ifdef MEM_LOADER_VERIFY_EN
            state_d  = S_VERIFY;
            vcount_d = '0;
            rsum_d   = '0;
`else
            state_d  = S_DONE;
`endif
          end
        end
      end
`ifdef MEM_LOADER_VERIFY_EN
      // Reads issue for vcount 0..len-1; data lands one cycle later,
      // so the final compare happens when vcount reaches len.
      S_VERIFY: begin
        vcount_d = vcount_q + ONE;
        if (vcount_q != '0) rsum_d = rsum_next;
        if (vcount_q == len_q)
          state_d = (rsum_next == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any load in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      count_q  <= '0;
      csum_q   <= '0;
`ifdef MEM_LOADER_VERIFY_EN
      vcount_q <= '0;
      rsum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      count_q  <= count_d;
      csum_q   <= csum_d;
`ifdef MEM_LOADER_VERIFY_EN
      vcount_q <= vcount_d;
      rsum_q   <= rsum_d;
`endif
    end
  end

  // Memory port: writes go out the same cycle a byte is accepted.
  always_comb begin
    mem_addr = '0;
    if (state_q == S_LOAD) mem_addr = base_q + count_q;
`ifdef MEM_LOADER_VERIFY_EN
    if (state_q == S_VERIFY) mem_addr = base_q + vcount_q;
`endif
  end

  assign s_ready      = (state_q == S_LOAD);
  assign mem_we       = accept;
  assign mem_din      = accept ? s_data : '0;
  assign core_reset_n = (state_q == S_DONE);
  assign done         = (state_q == S_DONE);
  assign checksum     = csum_q;

`ifdef MEM_LOADER_VERIFY_EN
  assign busy  = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign error = (state_q == S_ERROR);
`else
  assign busy  = (state_q == S_LOAD);
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a behavioural 64K x 8 memory.
// Expected verify latency follows MEM_LOADER_VERIFY_EN.
module tb_mem_loader;

`ifdef MEM_LOADER_VERIFY_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        core_reset_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  checksum;

  mem_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .core_reset_n(core_reset_n),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [23:0] wlog [$];
  logic        flip = 1'b0;

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_din;
      wlog.push_back({mem_addr, mem_din});
    end
    mem_dout <= mem[mem_addr] ^ {7'b0, flip};
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    string          name;
    logic [15:0]    base;
    logic [15:0]    len;
    logic [3:0][7:0] b;
    bit             gap;
    logic [7:0]     csum;
  } vec_t;

  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    @(negedge clk);
    wlog.delete();
    base_addr = b;
    length = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] d, output bit ok);
    int g = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = d;
    while (!s_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    ok = s_ready;
    @(posedge clk);
  endtask

  task automatic wait_idle(output int cnt);
    @(negedge clk);
    s_valid = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  vec_t vt [5];

  initial begin
    bit ok;
    int cnt;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    vt[0] = '{"b2b",   16'h0200, 16'd4, {8'h10,8'h85,8'h05,8'hA9}, 1'b0, 8'h43};
    vt[1] = '{"gap",   16'h0200, 16'd4, {8'h10,8'h85,8'h05,8'hA9}, 1'b1, 8'h43};
    vt[2] = '{"wrap",  16'hFFFF, 16'd2, {8'h00,8'h00,8'h22,8'h11}, 1'b0, 8'h33};
    vt[3] = '{"one",   16'h1234, 16'd1, {8'h00,8'h00,8'h00,8'h7F}, 1'b1, 8'h7F};
    vt[4] = '{"cwrap", 16'h0300, 16'd3, {8'h00,8'hF0,8'h90,8'h80}, 1'b0, 8'h00};

    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    s_valid = 1'b1;
    s_data = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_core_rst_n", core_reset_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_checksum", checksum, 0);
    s_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 0);

    for (int v = 0; v < 5; v++) begin
      do_start(vt[v].base, vt[v].len);
      ok = 1'b1;
      for (int i = 0; i < int'(vt[v].len); i++) begin
        if (vt[v].gap) begin
          @(negedge clk);
          s_valid = 1'b0;
        end
        if (ok) feed_byte(vt[v].b[i], ok);
      end
      chk({vt[v].name, "_accept"}, ok, 1);
      wait_idle(cnt);
      chk({vt[v].name, "_latency"}, cnt, VEN ? int'(vt[v].len) + 1 : 0);
      chk({vt[v].name, "_nwrites"}, wlog.size(), vt[v].len);
      for (int i = 0; i < int'(vt[v].len); i++) begin
        a = vt[v].base + 16'(i);
        if (i < wlog.size())
          chk({vt[v].name, "_wr"}, wlog[i], {a, vt[v].b[i]});
        chk({vt[v].name, "_mem"}, mem[a], vt[v].b[i]);
      end
      chk({vt[v].name, "_checksum"}, checksum, vt[v].csum);
      chk({vt[v].name, "_done"}, done, 1);
      chk({vt[v].name, "_core_rst_n"}, core_reset_n, 1);
      chk({vt[v].name, "_error"}, error, 0);
      chk({vt[v].name, "_busy"}, busy, 0);
    end
    chk("wrap_no_10000", mem[16'h0000], 8'h22);

    do_start(16'h0700, 16'd3);
    chk("load_core_rst_n", core_reset_n, 0);
    chk("load_done", done, 0);
    feed_byte(8'h01, ok);
    @(negedge clk);
    s_valid = 1'b0;
    base_addr = 16'h0500;
    length = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_s_ready", s_ready, 1);
    feed_byte(8'h02, ok);
    feed_byte(8'h03, ok);
    wait_idle(cnt);
    chk("busy_start_nwrites", wlog.size(), 3);
    if (wlog.size() == 3)
      chk("busy_start_wr2", wlog[2], {16'h0702, 8'h03});
    chk("busy_start_checksum", checksum, 8'h06);
    chk("busy_start_done", done, 1);

`ifdef MEM_LOADER_VERIFY_EN
    flip = 1'b1;
    do_start(16'h0600, 16'd2);
    feed_byte(8'h12, ok);
    feed_byte(8'h34, ok);
    wait_idle(cnt);
    flip = 1'b0;
    chk("verr_bound", cnt < 200, 1);
    chk("verr_error", error, 1);
    chk("verr_done", done, 0);
    chk("verr_core_rst_n", core_reset_n, 0);
    chk("verr_checksum", checksum, 8'h46);
`endif

    do_start(16'h0400, 16'd4);
    feed_byte(8'hAA, ok);
    feed_byte(8'hBB, ok);
    @(negedge clk);
    reset_n = 1'b0;
    s_valid = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_core_rst_n", core_reset_n, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_nwrites", wlog.size(), 2);
    chk("midrst_checksum", checksum, 0);
    chk("midrst_mem_untouched", mem[16'h0402], 8'h00);
    s_valid = 1'b0;

    do_start(16'h0800, 16'd0);
    chk("len0_done", done, 1);
    chk("len0_core_rst_n", core_reset_n, 1);
    chk("len0_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("len0_nwrites", wlog.size(), 0);
    chk("len0_checksum", checksum, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
